grf_wb_arbiter: RTL

- Owns the single GRF write port (RegWr/RWAddr/RWData) and shares it between two writers:
  - the pipeline W stage, which has priority and no backpressure;
  - the multi-cycle MDU result port, which uses a valid/ready handshake and a small FIFO.
- Keeps a scoreboard of registers with MDU writes in flight and raises a stall to decode on RAW/WAW hazards.
- Sits between W stage, MDU and GRF.

---
 rtl/grf_wb_arbiter_pkg.sv | 15 +
 rtl/grf_wb_arbiter_wb_fifo.sv | 54 +++++
 rtl/grf_wb_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared constants and write-source encoding for the GRF write-back arbiter.
// Widths match the architectural register file.
package grf_wb_arbiter_pkg;

   localparam int GRF_ADDR_W = 5;
   localparam int GRF_DATA_W = 32;
   localparam logic [GRF_ADDR_W-1:0] ZERO_REG = 5'd0;

   // Origin of the write held on the output registers; only MDU writes retire scoreboard bits.
   typedef enum logic {
      SRC_PIPE = 1'b0,
      SRC_MDU  = 1'b1
   } wb_src_e;

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Small power-of-two FIFO buffering MDU results that lost the GRF write port.
// Push is ignored while full and pop is ignored while empty.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: a cleared count makes stale entries unreachable.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Shares the single GRF write port between the W stage (priority) and the MDU,
// tracks in-flight MDU destinations and stalls decode on hazards or starvation.
module grf_wb_arbiter
   import grf_wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4,
   parameter int DATA_W       = GRF_DATA_W,
   parameter int ADDR_W       = GRF_ADDR_W
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              pipe_we,
   input  logic [ADDR_W-1:0] pipe_addr,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              mdu_issue,
   input  logic [ADDR_W-1:0] mdu_issue_addr,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_addr,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   output logic              stall,
   output logic              RegWr,
   output logic [ADDR_W-1:0] RWAddr,
   output logic [DATA_W-1:0] RWData
);

   localparam int NREG = 1 << ADDR_W;
   localparam int FW   = ADDR_W + DATA_W;
   localparam int CW   = $clog2(FIFO_DEPTH) + 1;
   localparam int GW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG);

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [FW-1:0]     fifo_head;
   logic              mdu_xfer;

   logic              sel_vld;
   wb_src_e           sel_src;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   wb_src_e           src_q;
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_set;
   logic [NREG-1:0]   busy_clr;
   logic [GW-1:0]     age;

   assign mdu_ready = !fifo_full;
   assign mdu_xfer  = mdu_valid && mdu_ready;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FW)
   ) u_fifo (
      .clk   (clk),
      .Reset (Reset),
      .push  (fifo_push),
      .wdata ({mdu_addr, mdu_data}),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Priority: W stage, then buffered MDU head, then same-cycle MDU bypass.
   always_comb begin
      sel_vld   = 1'b0;
      sel_src   = SRC_PIPE;
      sel_addr  = '0;
      sel_data  = '0;
      fifo_pop  = 1'b0;
      fifo_push = 1'b0;
      if (pipe_we) begin
         sel_vld   = 1'b1;
         sel_addr  = pipe_addr;
         sel_data  = pipe_data;
         fifo_push = mdu_xfer;
      end else if (!fifo_empty) begin
         sel_vld   = 1'b1;
         sel_src   = SRC_MDU;
         sel_addr  = fifo_head[FW-1:DATA_W];
         sel_data  = fifo_head[DATA_W-1:0];
         fifo_pop  = 1'b1;
         fifo_push = mdu_xfer;
      end else if (mdu_xfer) begin
         sel_vld   = 1'b1;
         sel_src   = SRC_MDU;
         sel_addr  = mdu_addr;
         sel_data  = mdu_data;
      end
   end

   // Writes to r0 still update address/data but never raise the enable.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         RegWr  <= 1'b0;
         RWAddr <= '0;
         RWData <= '0;
         src_q  <= SRC_PIPE;
      end else if (sel_vld) begin
         RegWr  <= (sel_addr != R0);
         RWAddr <= sel_addr;
         RWData <= sel_data;
         src_q  <= sel_src;
      end else begin
         RegWr  <= 1'b0;
      end
   end

   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (mdu_issue && (mdu_issue_addr != R0)) busy_set[mdu_issue_addr] = 1'b1;
      if (RegWr && (src_q == SRC_MDU))         busy_clr[RWAddr]         = 1'b1;
   end

   // A retiring write and a fresh issue to the same register leave it busy.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) busy <= '0;
      else        busy <= (busy & ~busy_clr) | busy_set;
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         age <= '0;
      end else if ((fifo_count == '0) || fifo_pop) begin
         age <= '0;
      end else if (age < GW'(STARVE_LIMIT)) begin
         age <= age + 1'b1;
      end
   end

   assign stall = (busy[rs] && (rs != R0)) ||
                  (busy[rt] && (rt != R0)) ||
                  (busy[rd] && (rd != R0)) ||
                  (age >= GW'(STARVE_LIMIT));

endmodule
